// File: rtl/ptch_fusion.sv
// Pitch fusion: integrates an offset-compensated gyro pitch rate into a saturating
// accumulator. Define PTCH_FUSION_ACCEL_EN to enable the accelerometer-Z fusion correction.
module ptch_fusion #(
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0,
  parameter int unsigned SETTLE_SMPLS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        raw_vld,
  input  logic [15:0] ptch_rt_raw,
  input  logic [15:0] AZ_raw,
  input  logic        rider_off,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt,
  output logic        vld
);

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_SMPLS - 1);
  localparam logic [26:0] INT_MAX     = 27'h3FF_FFFF;
  localparam logic [26:0] INT_MIN     = 27'h400_0000;

  state_t             state;
  logic [7:0]         settle_cnt;
  logic signed [26:0] ptch_int;

  logic signed [15:0] rt_comp;
  logic signed [15:0] fusion_offset;
  logic signed [28:0] sum;
  logic signed [26:0] int_next;
  logic               accept;

  assign accept = raw_vld && !rider_off;

  always_comb begin
    rt_comp = ptch_rt_raw - PTCH_RT_OFFSET;
  end

`ifdef PTCH_FUSION_ACCEL_EN
  logic signed [15:0] az_comp;
  logic signed [25:0] acc_prod;
  logic signed [15:0] ptch_acc;

  always_comb begin
    az_comp  = AZ_raw - AZ_OFFSET;
    acc_prod = az_comp * 26'sd327;
    // Keep product bits [25:13], sign-extended: effectively a divide by 8192.
    ptch_acc = {{3{acc_prod[25]}}, acc_prod[25:13]};
    if (ptch_acc > $signed(ptch)) begin
      fusion_offset = 16'sd1024;
    end else begin
      fusion_offset = -16'sd1024;
    end
  end
`else
  logic unused_az;
  assign unused_az = ^{AZ_raw, AZ_OFFSET};

  always_comb begin
    fusion_offset = '0;
  end
`endif

  // Two guard bits above the 27-bit accumulator expose overflow for saturation.
  always_comb begin
    sum = {{2{ptch_int[26]}}, ptch_int}
        - {{13{rt_comp[15]}}, rt_comp}
        + {{13{fusion_offset[15]}}, fusion_offset};
    if (!sum[28] && (sum[27:26] != 2'b00)) begin
      int_next = INT_MAX;
    end else if (sum[28] && (sum[27:26] != 2'b11)) begin
      int_next = INT_MIN;
    end else begin
      int_next = sum[26:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      ptch_int   <= '0;
      ptch       <= '0;
      ptch_rt    <= '0;
      vld        <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (rider_off) begin
        state      <= SETTLE;
        settle_cnt <= '0;
        ptch_int   <= '0;
        ptch       <= '0;
      end else if (accept) begin
        ptch_int <= int_next;
        ptch     <= int_next[26:11];
        ptch_rt  <= rt_comp;
        case (state)
          SETTLE: begin
            settle_cnt <= settle_cnt + 8'd1;
            if (settle_cnt == SETTLE_LAST) begin
              state <= RUN;
            end
          end
          RUN: begin
            vld <= 1'b1;
          end
          default: begin
            state <= SETTLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ptch_fusion.sv
// Scoreboard bench for ptch_fusion: the stimulus side pushes expected outputs,
// a negedge monitor pops and compares them whenever vld is seen.
module tb_ptch_fusion;

  localparam logic [15:0] RT_OFF = 16'h0050;
  localparam logic [15:0] AZ_OFF = 16'h00A0;
  localparam int          SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        raw_vld;
  logic [15:0] ptch_rt_raw;
  logic [15:0] AZ_raw;
  logic        rider_off;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;
  logic        vld;

  ptch_fusion #(
    .PTCH_RT_OFFSET(RT_OFF),
    .AZ_OFFSET     (AZ_OFF),
    .SETTLE_SMPLS  (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_vld    (raw_vld),
    .ptch_rt_raw(ptch_rt_raw),
    .AZ_raw     (AZ_raw),
    .rider_off  (rider_off),
    .ptch       (ptch),
    .ptch_rt    (ptch_rt),
    .vld        (vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [15:0] r;
    int          c;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  longint      m_int  = 0;
  logic [15:0] m_ptch = '0;
  logic [15:0] m_rt   = '0;
  int          m_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: vld=1 at cycle %0d, required no vld", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (ptch !== e.p || ptch_rt !== e.r || cyc != e.c) begin
          errors++;
          $display("FAIL sample: got ptch=%h ptch_rt=%h cycle=%0d, required ptch=%h ptch_rt=%h cycle=%0d",
                   ptch, ptch_rt, cyc, e.p, e.r, e.c);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge and advance the reference model to
  // the state the DUT will hold after the following posedge.
  task automatic drive(input logic r, input logic rv, input logic [15:0] rt,
                       input logic [15:0] az, input logic ro);
    logic [15:0] rtc;
    longint      fo;
    @(negedge clk);
    rst = r; raw_vld = rv; ptch_rt_raw = rt; AZ_raw = az; rider_off = ro;
    fo = 0;
    if (r) begin
      m_int = 0; m_ptch = '0; m_rt = '0; m_cnt = 0;
    end else if (ro) begin
      m_int = 0; m_ptch = '0; m_cnt = 0;
    end else if (rv) begin
      rtc = rt - RT_OFF;
`ifdef PTCH_FUSION_ACCEL_EN
      begin
        logic [15:0] azc;
        int          prod;
        int          acc;
        azc  = az - AZ_OFF;
        prod = int'($signed(azc)) * 327;
        acc  = prod >>> 13;
        fo   = (acc > int'($signed(m_ptch))) ? 1024 : -1024;
      end
`endif
      m_int = m_int - longint'($signed(rtc)) + fo;
      if (m_int > 64'sd67108863) m_int = 67108863;
      if (m_int < -64'sd67108864) m_int = -67108864;
      m_ptch = 16'(m_int >>> 11);
      m_rt   = rtc;
      if (m_cnt < SETTLE) m_cnt++;
      else q.push_back('{p: m_ptch, r: m_rt, c: cyc + 1});
    end
  endtask

  task automatic sample(input logic [15:0] rt, input logic [15:0] az);
    drive(1'b0, 1'b1, rt, az, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; raw_vld = 1'b0; ptch_rt_raw = '0; AZ_raw = '0; rider_off = 1'b0;

    // Reset with a sample present: sample dropped, all outputs cleared.
    repeat (3) drive(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0);
    idle();
    chk("reset_ptch", ptch, 16'h0000);
    chk("reset_ptch_rt", ptch_rt, 16'h0000);
    chk("reset_vld", {15'b0, vld}, 16'h0000);

    // Zero-rate samples: 16 silent settle samples, then the 17th produces vld.
    repeat (SETTLE) sample(16'h0050, 16'h00A0);
    idle();
    chk("settle_no_vld", {15'b0, vld}, 16'h0000);
    sample(16'h0050, 16'h00A0);
    idle();
    chk("first_run_ptch_rt", ptch_rt, 16'h0000);
    repeat (3) sample(16'h0050, 16'h00A0);

    // Constant +256 compensated rate for 2048 samples.
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    repeat (SETTLE) sample(16'h0050, 16'h00A0);
    repeat (2048) sample(16'h0150, 16'h00A0);
    idle();
`ifndef PTCH_FUSION_ACCEL_EN
    chk("gyro_ramp_ptch", ptch, 16'hFF00);
`endif
    chk("gyro_ramp_ptch_rt", ptch_rt, 16'h0100);

    // Most-negative rate: accumulator must saturate at the positive limit.
    repeat (2100) sample(16'h8050, 16'h00A0);
    idle();
    chk("sat_ptch", ptch, 16'h7FFF);
    chk("sat_ptch_rt", ptch_rt, 16'h8000);

    // Clear together with a sample: dropped, ptch zeroed, ptch_rt held.
    drive(1'b0, 1'b1, 16'h1234, 16'h00A0, 1'b1);
    idle();
    chk("clear_ptch", ptch, 16'h0000);
    chk("clear_ptch_rt_hold", ptch_rt, 16'h8000);
    chk("clear_vld", {15'b0, vld}, 16'h0000);
    idle();
    chk("clear_vld_next", {15'b0, vld}, 16'h0000);
    for (int i = 0; i < SETTLE; i++) sample(16'h0050 + 16'(i * 8), 16'h00A0);
    sample(16'h0070, 16'h00A0);

    // Three back-to-back samples, then samples separated by idle cycles.
    sample(16'h0060, 16'h00A0);
    sample(16'h0040, 16'h00A0);
    sample(16'h0150, 16'h00A0);
    idle();
    sample(16'hFF50, 16'h00A0);
    idle();
    idle();
    sample(16'h7FFF, 16'h00A0);

    // Positive AZ: with fusion, ptch climbs toward and dithers around 163.
    repeat (60) sample(16'h0050, 16'h10A0);
    repeat (10) sample(16'h0050, 16'hF0A0);

    // Reset mid-settle restarts settle from scratch.
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    repeat (5) sample(16'h0090, 16'h00A0);
    drive(1'b1, 1'b1, 16'h0090, 16'h00A0, 1'b1);
    idle();
    chk("midsettle_rst_ptch", ptch, 16'h0000);
    chk("midsettle_rst_ptch_rt", ptch_rt, 16'h0000);

    // raw_vld held across rider_off release: first sample after release is settle 1.
    repeat (2) drive(1'b0, 1'b1, 16'h0030, 16'h00A0, 1'b1);
    repeat (SETTLE + 3) sample(16'h0030, 16'h00A0);
    repeat (5) idle();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_vld: %0d expected samples never presented, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptch_fusion.md
PTCH_FUSION -- requirements
Module: ptch_fusion

Interface
REQ-001 Parameter PTCH_RT_OFFSET, default 16'h0050: gyro pitch-rate zero offset, subtracted from every raw rate sample.
REQ-002 Parameter AZ_OFFSET, default 16'h00A0: accelerometer Z zero offset, subtracted from every raw AZ sample.
REQ-003 Parameter SETTLE_SMPLS, default 16 (range 1-255): accepted samples discarded after reset or clear before vld is allowed.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 raw_vld  input  1  one-cycle strobe; ptch_rt_raw and AZ_raw are valid this cycle.
REQ-007 ptch_rt_raw  input  16  signed raw gyro pitch rate.
REQ-008 AZ_raw  input  16  signed raw accelerometer Z.
REQ-009 rider_off  input  1  level; clears pitch estimate and restarts settle.
REQ-010 ptch  output  16  signed fused pitch estimate, registered.
REQ-011 ptch_rt  output  16  signed offset-compensated pitch rate, registered.
REQ-012 vld  output  1  one-cycle strobe; ptch and ptch_rt are updated and valid this cycle.

Function
REQ-013 ptch_rt_comp = ptch_rt_raw - PTCH_RT_OFFSET (16-bit, two's-complement wrap); AZ_comp = AZ_raw - AZ_OFFSET (same).
REQ-014 ptch_acc_product = AZ_comp * 327 (signed, 26 bits); ptch_acc = sign-extend(ptch_acc_product[25:13]) to 16 bits.
REQ-015 fusion_offset = +1024 when ptch_acc > ptch (signed compare against current registered ptch), else -1024.
REQ-016 ptch_int is a 27-bit signed accumulator; on each accepted sample: ptch_int <= ptch_int - sext27(ptch_rt_comp) + sext27(fusion_offset).
REQ-017 ptch_int saturates: a sum above 27'h3FFFFFF holds 27'h3FFFFFF; a sum below 27'h4000000 (most negative) holds 27'h4000000; no wrap.
REQ-018 ptch = ptch_int[26:11]; ptch_rt = ptch_rt_comp registered on the accepted sample.
REQ-019 A sample is accepted when raw_vld=1 and rider_off=0; ptch_int, ptch and ptch_rt change only on accepted samples.
REQ-020 Latency: ptch_int updates at the edge ending the raw_vld cycle; ptch/ptch_rt reflect it and vld pulses exactly one cycle after raw_vld.
REQ-021 State machine SETTLE -> RUN: SETTLE counts accepted samples (8-bit counter); after SETTLE_SMPLS samples go to RUN; vld held 0 in SETTLE, including for the final settle sample.
REQ-022 In RUN every accepted sample produces exactly one vld pulse; back-to-back raw_vld on consecutive cycles produces back-to-back vld.
REQ-023 rider_off=1: ptch_int <= 0, ptch <= 0, settle counter <= 0, state <= SETTLE, vld <= 0; ptch_rt holds.
REQ-024 rider_off=1 and raw_vld=1 in the same cycle: clear wins; sample dropped; no vld.
REQ-025 raw_vld while rider_off deasserts: first accepted sample is the first raw_vld with rider_off=0; it counts as settle sample 1.

Reset
REQ-026 rst=1 at a clock edge: ptch_int=0, ptch=0, ptch_rt=0, vld=0, settle counter=0, state=SETTLE.
REQ-027 rst overrides rider_off and raw_vld; a sample presented in a reset cycle is dropped; reset asserted mid-stream or mid-settle fully restarts settle.

Configuration
REQ-028 Macro PTCH_FUSION_ACCEL_EN: defined -> fusion per REQ-014/015; undefined -> fusion_offset forced to 0, pure gyro integration, AZ_raw ignored and accel multiplier not synthesised; all other behaviour identical.

Verification
REQ-029 rst, then 16 raw_vld with ptch_rt_raw=16'h0050, AZ_raw=16'h00A0 -> no vld; 17th sample -> vld one cycle later, ptch_rt=0; with macro, ptch moves toward 0 by +/-1024 LSB of ptch_int per sample.
REQ-030 Macro undefined, after settle, 2048 samples ptch_rt_raw=16'h0050+16'h0100 -> ptch_int=-2048*256=27'h7F80000, ptch=16'hFF00 (ptch_int[26:11]=-256).
REQ-031 Macro undefined, hold ptch_rt_raw=16'h8050 (comp -32768) continuously -> ptch_int climbs to 27'h3FFFFFF and holds; ptch=16'h7FFF; no wrap.
REQ-032 Macro defined, AZ_raw=16'h10A0 (AZ_comp=4096), ptch_rt_raw=16'h0050 -> ptch_acc=163, fusion_offset=+1024 each sample until ptch exceeds 163, then ptch dithers around 163.
REQ-033 In RUN, assert rider_off together with raw_vld -> no vld that cycle or next, ptch=0; next 16 accepted samples produce no vld, 17th produces vld.
REQ-034 In RUN, raw_vld on 3 consecutive cycles -> vld high 3 consecutive cycles, each one cycle after its raw_vld; ptch_rt tracks each sample.
